// File: rtl/ssram_stream_reader_if.sv
// SSRAM read port plus valid/ready output stream of the stream reader.
// master = reader side, slave = memory + sink side.
interface ssram_stream_reader_if #(
   parameter int unsigned bitwidth  = 32,
   parameter int unsigned addrWidth = 9
);
   logic [addrWidth-1:0] ramAddress;
   logic                 ramWriteEnable;
   logic [bitwidth-1:0]  ramDataOut;
   logic [bitwidth-1:0]  streamData;
   logic                 streamValid;
   logic                 streamReady;

   modport master (
      output ramAddress, ramWriteEnable, streamData, streamValid,
      input  ramDataOut, streamReady
   );

   modport slave (
      input  ramAddress, ramWriteEnable, streamData, streamValid,
      output ramDataOut, streamReady
   );
endinterface

// File: rtl/ssram_stream_reader.sv
// Sequential SSRAM read engine: issues reads on a 1-cycle-latency port and
// streams the words out through a 4-entry FIFO under arbitrary backpressure.
module ssram_stream_reader #(
   parameter int unsigned bitwidth    = 32,
   parameter int unsigned nrOfEntries = 512,
   localparam int unsigned AW         = $clog2(nrOfEntries)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] startAddress,
   input  logic [AW:0]   wordCount,
   output logic          busy,
   output logic          done,
   ssram_stream_reader_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFinish} state_t;

   state_t              state;
   logic [AW-1:0]       pointer;
   logic [AW-1:0]       ramAddressReg;
   logic [AW:0]         remaining;
   logic [AW:0]         outstanding;
   // issuePipe[0]: address issued last edge; issuePipe[1]: its data is on ramDataOut now
   logic [1:0]          issuePipe;
   logic [2:0]          inFlight;
   logic [bitwidth-1:0] fifo [4];
   logic [1:0]          wrPtr;
   logic [1:0]          rdPtr;
   logic [2:0]          fifoCount;
   logic                issue;
   logic                push;
   logic                pop;

   assign inFlight = {2'b00, issuePipe[0]} + {2'b00, issuePipe[1]};
   // Pre-edge occupancy only; a same-edge pop does not free a slot until the next edge.
   assign issue    = (state == StRun) && (remaining != '0) && ((fifoCount + inFlight) < 3'd4);
   assign push     = issuePipe[1];
   assign pop      = (fifoCount != 3'd0) && bus.streamReady;

   assign bus.ramAddress     = ramAddressReg;
   assign bus.ramWriteEnable = 1'b0;
   assign bus.streamData     = fifo[rdPtr];
   assign bus.streamValid    = (fifoCount != 3'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         pointer       <= '0;
         ramAddressReg <= '0;
         remaining     <= '0;
         outstanding   <= '0;
         issuePipe     <= '0;
         wrPtr         <= '0;
         rdPtr         <= '0;
         fifoCount     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            fifo[i] <= '0;
         end
      end else begin
         issuePipe <= {issuePipe[0], issue};
         if (issue) begin
            ramAddressReg <= pointer;
            pointer       <= pointer + AW'(1);
            remaining     <= remaining - (AW+1)'(1);
         end
         if (push) begin
            fifo[wrPtr] <= bus.ramDataOut;
            wrPtr       <= wrPtr + 2'd1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 2'd1;
         end
         if (push && !pop) begin
            fifoCount <= fifoCount + 3'd1;
         end else if (!push && pop) begin
            fifoCount <= fifoCount - 3'd1;
         end

         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  if (wordCount != '0) begin
                     pointer     <= startAddress;
                     remaining   <= wordCount;
                     outstanding <= wordCount;
                     busy        <= 1'b1;
                     state       <= StRun;
                  end else begin
                     done  <= 1'b1;
                     state <= StFinish;
                  end
               end
            end
            StRun: begin
               if (pop) begin
                  outstanding <= outstanding - (AW+1)'(1);
                  if (outstanding == (AW+1)'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= StFinish;
                  end
               end
            end
            StFinish: state <= StIdle;
            default:  state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ssram_stream_reader.sv
// Directed bench for ssram_stream_reader: SSRAM model, stream scoreboard,
// occupancy invariant and done-pulse accounting.
module tb_ssram_stream_reader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [8:0]  startAddress;
   logic [9:0]  wordCount;
   logic        busy;
   logic        done;
   logic [31:0] mem [512];
   logic [31:0] q [$];
   logic [31:0] expWord;
   int          total;
   int          bad;
   int          donePulses;
   int          accepted;
   int          occ;
   int          base;
   int          cycles;
   int          busyCycles;
   int          n;

   ssram_stream_reader_if #(.bitwidth(32), .addrWidth(9)) bus ();

   ssram_stream_reader #(.bitwidth(32), .nrOfEntries(512)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .startAddress (startAddress),
      .wordCount    (wordCount),
      .busy         (busy),
      .done         (done),
      .bus          (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One-cycle registered-read SSRAM.
   always @(posedge clock) bus.ramDataOut <= mem[bus.ramAddress];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (busy) begin
            occ = int'(dut.fifoCount) + int'(dut.inFlight);
            check("occupancy_le_4", 64'(occ <= 4), 64'd1);
         end
         if (done) donePulses++;
         if (bus.streamValid && bus.streamReady) begin
            check("sb_word_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               expWord = q.pop_front();
               check("stream_data", 64'(bus.streamData), 64'(expWord));
            end
            accepted++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_xfer(input int addr, input int cnt);
      start        = 1'b1;
      startAddress = addr[8:0];
      wordCount    = cnt[9:0];
      for (int i = 0; i < cnt; i++) q.push_back(32'h1000 + 32'((addr + i) % 512));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit rnd, output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      while (!done && cyc < limit) begin
         if (busy) bcyc++;
         if (rnd) bus.streamReady = ($urandom_range(0, 9) < 3);
         tick();
         cyc++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("busy_low_at_done", 64'(busy), 64'd0);
      bus.streamReady = 1'b1;
   endtask

   task automatic finish_xfer(input string tag);
      tick();
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_one_done_pulse"}, 64'(donePulses - base), 64'd1);
      check({tag, "_all_words"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; donePulses = 0; accepted = 0;
      for (int k = 0; k < 512; k++) mem[k] = 32'h1000 + 32'(k);
      reset = 1'b1; start = 1'b0; startAddress = '0; wordCount = '0;
      bus.streamReady = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_valid", 64'(bus.streamValid), 64'd0);
      check("rst_data", 64'(bus.streamData), 64'd0);
      check("rst_addr", 64'(bus.ramAddress), 64'd0);
      check("rst_we", 64'(bus.ramWriteEnable), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // Basic 4-word read: first valid after the third edge past start.
      base = donePulses;
      bus.streamReady = 1'b1;
      start_xfer(10, 4);
      check("t1_busy_e0", 64'(busy), 64'd1);
      check("t1_valid_e0", 64'(bus.streamValid), 64'd0);
      tick();
      check("t1_addr_e1", 64'(bus.ramAddress), 64'd10);
      check("t1_valid_e1", 64'(bus.streamValid), 64'd0);
      tick();
      check("t1_valid_e2", 64'(bus.streamValid), 64'd0);
      tick();
      check("t1_valid_e3", 64'(bus.streamValid), 64'd1);
      check("t1_data_e3", 64'(bus.streamData), 64'h100A);
      check("t1_we", 64'(bus.ramWriteEnable), 64'd0);
      wait_done(50, 1'b0, cycles, busyCycles);
      // Handshakes at E4..E7, done visible after E7.
      check("t1_done_latency", 64'(cycles), 64'd4);
      check("t1_busy_cycles", 64'(busyCycles), 64'd4);
      finish_xfer("t1");

      // Zero-length transfer.
      base = donePulses;
      start_xfer(300, 0);
      check("t4_done_pulse", 64'(done), 64'd1);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_addr_held", 64'(bus.ramAddress), 64'd13);
      check("t4_valid", 64'(bus.streamValid), 64'd0);
      finish_xfer("t4");

      // Address wrap at the top of memory.
      base = donePulses;
      start_xfer(510, 4);
      tick(); check("t2_addr0", 64'(bus.ramAddress), 64'd510);
      tick(); check("t2_addr1", 64'(bus.ramAddress), 64'd511);
      tick(); check("t2_addr2", 64'(bus.ramAddress), 64'd0);
      tick(); check("t2_addr3", 64'(bus.ramAddress), 64'd1);
      wait_done(50, 1'b0, cycles, busyCycles);
      finish_xfer("t2");

      // Full backpressure: four words buffered, issue resumes the edge after the first pop.
      base = donePulses;
      bus.streamReady = 1'b0;
      start_xfer(200, 8);
      repeat (10) tick();
      check("bp_addr_stalled", 64'(bus.ramAddress), 64'd203);
      check("bp_valid", 64'(bus.streamValid), 64'd1);
      check("bp_head", 64'(bus.streamData), 64'h10C8);
      bus.streamReady = 1'b1;
      tick(); check("bp_no_issue_on_pop", 64'(bus.ramAddress), 64'd203);
      tick(); check("bp_resume", 64'(bus.ramAddress), 64'd204);
      wait_done(50, 1'b0, cycles, busyCycles);
      finish_xfer("bp");

      // 64 words under random 30% ready.
      base = donePulses;
      start_xfer(100, 64);
      wait_done(3000, 1'b1, cycles, busyCycles);
      check("t3_last_addr", 64'(bus.ramAddress), 64'd163);
      finish_xfer("t3");

      // Start while busy is ignored.
      base = donePulses;
      start_xfer(20, 8);
      tick();
      tick();
      start = 1'b1; startAddress = 9'd400; wordCount = 10'd3;
      tick();
      start = 1'b0;
      wait_done(50, 1'b0, cycles, busyCycles);
      check("t5_last_addr", 64'(bus.ramAddress), 64'd27);
      finish_xfer("t5");

      // Reset after three accepted words, then a fresh 2-word transfer.
      base = accepted;
      start_xfer(40, 8);
      n = 0;
      while (accepted - base < 3 && n < 50) begin
         tick();
         n++;
      end
      check("t6_three_accepted", 64'(accepted - base), 64'd3);
      reset = 1'b1;
      #1;
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_valid", 64'(bus.streamValid), 64'd0);
      check("t6_rst_data", 64'(bus.streamData), 64'd0);
      check("t6_rst_addr", 64'(bus.ramAddress), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      q.delete();
      tick();
      reset = 1'b0;
      tick();
      check("t6_idle_after_rst", 64'(busy), 64'd0);
      base = donePulses;
      start_xfer(0, 2);
      wait_done(50, 1'b0, cycles, busyCycles);
      finish_xfer("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
